// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and data access.
// Data requests win ties; a watchdog aborts any access the memory never completes.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              stall_o,
    output logic              err_o,
    output logic [1:0]        dbg_state
);

    // Handshake: a requester holds req (and its address/data) stable until it sees
    // its one-cycle ack; the memory completes an access with a one-cycle mem_ready_i
    // while mem_req_o is high. mem_ready_i outside a busy state is ignored.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wd_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wd_cnt      <= 8'd0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_ack_o    <= 1'b0;
            d_ack_o     <= 1'b0;
            if_rdata_o  <= '0;
            d_rdata_o   <= '0;
            err_o       <= 1'b0;
        end else begin
            if_ack_o <= 1'b0;
            d_ack_o  <= 1'b0;
            case (state)
                IDLE: begin
                    wd_cnt <= 8'd0;
                    if (d_req_i) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= d_we_i;
                        mem_addr_o  <= d_addr_i;
                        mem_wdata_o <= d_wdata_i;
                        state       <= BUSY_D;
                    end else if (if_req_i) begin
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= if_addr_i;
                        state      <= BUSY_I;
                    end
                end
                BUSY_D, BUSY_I: begin
                    // A ready arriving on the expiry cycle still completes normally.
                    if (mem_ready_i) begin
                        mem_req_o <= 1'b0;
                        state     <= RESP;
                        if (state == BUSY_D) begin
                            d_ack_o <= 1'b1;
                            if (!mem_we_o) d_rdata_o <= mem_rdata_i;
                        end else begin
                            if_ack_o   <= 1'b1;
                            if_rdata_o <= mem_rdata_i;
                        end
                    end else if (wd_cnt == WD_LAST) begin
                        mem_req_o <= 1'b0;
                        err_o     <= 1'b1;
                        state     <= RESP;
                        if (state == BUSY_D) begin
                            d_ack_o <= 1'b1;
                            if (!mem_we_o) d_rdata_o <= '0;
                        end else begin
                            if_ack_o   <= 1'b1;
                            if_rdata_o <= '0;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall_o   = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, priority, store, watchdog, back-to-back.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          stall;
    logic          err;
    logic [1:0]    dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_ack_cyc;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_word;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rdata_o(d_rdata), .d_ack_o(d_ack),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
        .stall_o(stall), .err_o(err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1;
        for (int i = 0; i < cycles; i++) step();
        rst = 0;
    endtask

    task automatic mem_respond(input logic [DW-1:0] data);
        mem_ready = 1; mem_rdata = data;
        step();
        mem_ready = 0; mem_rdata = '0;
    endtask

    initial begin
        quiet_inputs();
        do_reset(2);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);

        // reset in the middle of a data access
        d_req = 1; d_addr = 32'h300;
        step();
        check("rstmid_req", 32'(mem_req), 32'd1);
        check("rstmid_addr", mem_addr, 32'h300);
        check("rstmid_stall", 32'(stall), 32'd1);
        step();
        rst = 1; step(); step(); rst = 0;
        quiet_inputs();
        check("rstmid_req0", 32'(mem_req), 32'd0);
        check("rstmid_addr0", mem_addr, 32'h0);
        check("rstmid_dack0", 32'(d_ack), 32'd0);
        check("rstmid_err0", 32'(err), 32'd0);
        mem_respond(32'hABCD_0123);
        check("late_ready_dack", 32'(d_ack), 32'd0);
        check("late_ready_iack", 32'(if_ack), 32'd0);
        check("late_ready_rdata", d_rdata, 32'h0);
        check("late_ready_state", 32'(dbg_state), 32'd0);

        // single fetch, ready three cycles after acceptance
        if_req = 1; if_addr = 32'h40;
        #1 check("fetch_stall_pre", 32'(stall), 32'd1);
        step();
        check("fetch_req", 32'(mem_req), 32'd1);
        check("fetch_addr", mem_addr, 32'h40);
        check("fetch_we", 32'(mem_we), 32'd0);
        check("fetch_state", 32'(dbg_state), 32'd2);
        step(); step();
        check("fetch_stall_wait", 32'(stall), 32'd1);
        check("fetch_noack", 32'(if_ack), 32'd0);
        mem_respond(32'h2008_0005);
        check("fetch_ack", 32'(if_ack), 32'd1);
        check("fetch_rdata", if_rdata, 32'h2008_0005);
        check("fetch_stall_ack", 32'(stall), 32'd0);
        check("fetch_req_drop", 32'(mem_req), 32'd0);
        check("fetch_state_resp", 32'(dbg_state), 32'd3);
        if_req = 0;
        step();
        check("fetch_ack_once", 32'(if_ack), 32'd0);
        check("fetch_idle", 32'(dbg_state), 32'd0);

        // simultaneous requests: data first
        d_req = 1; d_we = 0; d_addr = 32'h100;
        if_req = 1; if_addr = 32'h44;
        step();
        check("prio_addr_d", mem_addr, 32'h100);
        check("prio_state_d", 32'(dbg_state), 32'd1);
        mem_respond(32'h1111_2222);
        check("prio_dack", 32'(d_ack), 32'd1);
        check("prio_drdata", d_rdata, 32'h1111_2222);
        check("prio_iack0", 32'(if_ack), 32'd0);
        check("prio_stall_if", 32'(stall), 32'd1);
        d_req = 0;
        step();
        check("prio_idle_gap", 32'(mem_req), 32'd0);
        check("prio_dack_once", 32'(d_ack), 32'd0);
        step();
        check("prio_addr_i", mem_addr, 32'h44);
        check("prio_req_i", 32'(mem_req), 32'd1);
        mem_respond(32'h3333_4444);
        check("prio_iack", 32'(if_ack), 32'd1);
        check("prio_irdata", if_rdata, 32'h3333_4444);
        if_req = 0;
        step();

        // store leaves d_rdata untouched
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
        step();
        check("st_we", 32'(mem_we), 32'd1);
        check("st_addr", mem_addr, 32'h200);
        check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_respond(32'h5555_5555);
        check("st_dack", 32'(d_ack), 32'd1);
        check("st_rdata_hold", d_rdata, 32'h1111_2222);
        quiet_inputs();
        step();

        // watchdog expiry with TIMEOUT = 8
        d_req = 1; d_we = 0; d_addr = 32'h400;
        step();
        for (int i = 0; i < 7; i++) step();
        check("to_req_held", 32'(mem_req), 32'd1);
        check("to_noack", 32'(d_ack), 32'd0);
        check("to_err_pre", 32'(err), 32'd0);
        step();
        check("to_req_drop", 32'(mem_req), 32'd0);
        check("to_dack", 32'(d_ack), 32'd1);
        check("to_rdata0", d_rdata, 32'h0);
        check("to_err", 32'(err), 32'd1);
        quiet_inputs();
        step();
        step();
        check("to_err_sticky", 32'(err), 32'd1);
        do_reset(1);
        check("to_err_clr", 32'(err), 32'd0);

        // ready on the expiry cycle completes normally
        d_req = 1; d_we = 0; d_addr = 32'h500;
        step();
        for (int i = 0; i < 7; i++) step();
        mem_respond(32'h7777_8888);
        check("race_dack", 32'(d_ack), 32'd1);
        check("race_rdata", d_rdata, 32'h7777_8888);
        check("race_err", 32'(err), 32'd0);
        quiet_inputs();
        step();

        // back-to-back fetches, ready held high so RESP/IDLE readies must be ignored
        if_req = 1; if_addr = 32'h80;
        mem_ready = 1;
        last_ack_cyc = -1;
        for (int k = 0; k < 3; k++) begin
            exp_word = 32'hC0DE_0000 + 32'(k);
            mem_rdata = exp_word;
            exp_q.push_back(exp_word);
            step();
            check("b2b_req", 32'(mem_req), 32'd1);
            check("b2b_addr", mem_addr, 32'h80 + 32'(4 * k));
            check("b2b_noack", 32'(if_ack), 32'd0);
            step();
            check("b2b_ack", 32'(if_ack), 32'd1);
            if (exp_q.size() > 0) check("b2b_rdata", if_rdata, exp_q.pop_front());
            if (last_ack_cyc >= 0) check("b2b_period", 32'(cyc - last_ack_cyc), 32'd3);
            last_ack_cyc = cyc;
            if_addr = 32'h80 + 32'(4 * (k + 1));
            step();
            check("b2b_gap_req", 32'(mem_req), 32'd0);
            check("b2b_gap_ack", 32'(if_ack), 32'd0);
            check("b2b_gap_state", 32'(dbg_state), 32'd0);
        end
        quiet_inputs();
        step();
        check("b2b_end_state", 32'(dbg_state), 32'd0);
        check("b2b_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
